// File: rtl/accel_pkg.sv
// Shared types and constants for the mesh configuration path: loader states,
// configuration packet type, switch port encodings and the idle (NOP) word.
package accel_pkg;

  typedef logic [47:0] cfg_pkt_t;

  localparam cfg_pkt_t CFG_NOP = 48'h0;

  localparam logic [1:0] SOUTH = 2'd0;
  localparam logic [1:0] EAST  = 2'd1;
  localparam logic [1:0] NORTH = 2'd2;
  localparam logic [1:0] WEST  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StRun,
    StFin
  } loader_state_e;

  // Routing header of a configuration packet; 8'h00 addresses no tile.
  function automatic logic [7:0] cfg_hdr(input cfg_pkt_t pkt);
    return pkt[47:40];
  endfunction

endpackage

// File: rtl/cfg_fifo.sv
// First-word-fall-through buffer for configuration packets. Pointers carry an
// extra wrap bit so full and empty are distinguishable at equal indices.
module cfg_fifo
  import accel_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  cfg_pkt_t wdata_i,
  input  logic     pop_i,
  output cfg_pkt_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;

  cfg_pkt_t        mem_q [Depth];
  logic     [Aw:0] wr_ptr_q, wr_ptr_d;
  logic     [Aw:0] rd_ptr_q, rd_ptr_d;
  logic            do_push, do_pop;

  assign full_o  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q[Aw-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only visible between the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[Aw-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/config_loader.sv
// Streams buffered configuration packets into the mesh entry switch, drains,
// runs for a programmed cycle count and pulses done. Optional CONFIG_LOADER_ERR_EN
// adds a sticky err flag and suppresses packets with a zero routing header.
module config_loader
  import accel_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [1:0]  ENTRY_PORT   = SOUTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_packets,
  input  logic [15:0]      run_cycles,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  logic [47:0]      pkt_data,
  output logic             load,
  output logic [1:0]       in_flag,
  output logic [47:0]      cfg_word,
  output logic             busy,
`ifdef CONFIG_LOADER_ERR_EN
  output logic             err,
`endif
  output logic             done
);

  loader_state_e    state_q, state_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [15:0]      run_q, run_d;
  logic [15:0]      tmr_q, tmr_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  cfg_pkt_t         cfg_q, cfg_d;
  logic             err_q, err_d;

  logic     fifo_full, fifo_empty, fifo_pop;
  cfg_pkt_t fifo_rdata;

  cfg_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_cfg_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .push_i (pkt_valid & pkt_ready),
    .wdata_i(pkt_data),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign pkt_ready = reset & ~fifo_full;
  assign in_flag   = ENTRY_PORT;
  assign load      = load_q;
  assign cfg_word  = cfg_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef CONFIG_LOADER_ERR_EN
  assign err       = err_q;
`endif

  always_comb begin
    state_d  = state_q;
    sent_d   = sent_q;
    num_d    = num_q;
    run_d    = run_q;
    tmr_d    = tmr_q;
    err_d    = err_q;
    cfg_d    = CFG_NOP;
    fifo_pop = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_d   = num_packets;
          run_d   = run_cycles;
          sent_d  = '0;
          tmr_d   = '0;
          state_d = (num_packets == '0) ? StDrain : StLoad;
        end
      end
      StLoad: begin
        if (sent_q == num_q) begin
          tmr_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (tmr_q == 16'(DRAIN_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = (run_q == '0) ? StFin : StRun;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      StRun: begin
        if (tmr_q + 16'd1 == run_q) begin
          state_d = StFin;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Popping on entry to each LOAD cycle keeps cfg_word aligned with load.
    fifo_pop = (state_d == StLoad) && !fifo_empty;
    if (fifo_pop) begin
      sent_d = sent_d + 1'b1;
      cfg_d  = fifo_rdata;
`ifdef CONFIG_LOADER_ERR_EN
      if (cfg_hdr(fifo_rdata) == 8'h00) begin
        cfg_d = CFG_NOP;
        err_d = 1'b1;
      end
`endif
    end

    load_d = (state_d == StLoad) || (state_d == StDrain);
    busy_d = (state_d != StIdle);
    done_d = (state_d == StFin);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sent_q  <= '0;
      num_q   <= '0;
      run_q   <= '0;
      tmr_q   <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cfg_q   <= CFG_NOP;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      num_q   <= num_d;
      run_q   <= run_d;
      tmr_q   <= tmr_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a vector table for the basic load/drain/run
// sequence plus hand-written multi-cycle corner cases.
module tb_config_loader;

  localparam logic [47:0] N  = 48'h0;
  localparam logic [47:0] WA = 48'hA1_0000_0000_01;
  localparam logic [47:0] WB = 48'hB2_0000_0000_02;
  localparam logic [47:0] WC = 48'hC3_0000_0000_03;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  num_packets;
  logic [15:0] run_cycles;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [47:0] pkt_data;
  logic        load;
  logic [1:0]  in_flag;
  logic [47:0] cfg_word;
  logic        busy;
  logic        done;
`ifdef CONFIG_LOADER_ERR_EN
  logic        err;
`endif

  int tests = 0;
  int fails = 0;
  logic e_err = 1'b0;

  always #5 clk = ~clk;

  config_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_packets(num_packets),
    .run_cycles (run_cycles),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_data   (pkt_data),
    .load       (load),
    .in_flag    (in_flag),
    .cfg_word   (cfg_word),
    .busy       (busy),
`ifdef CONFIG_LOADER_ERR_EN
    .err        (err),
`endif
    .done       (done)
  );

  typedef struct {
    logic        start;
    logic [7:0]  num;
    logic [15:0] run;
    logic        valid;
    logic [47:0] data;
    logic        e_load;
    logic [47:0] e_cfg;
    logic        e_busy;
    logic        e_done;
    logic        e_ready;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Checks outputs mid-cycle, then advances to just after the next rising edge.
  task automatic cyc(input string tag, input logic e_load, input logic [47:0] e_cfg,
                     input logic e_busy, input logic e_done, input logic e_ready);
    @(negedge clk);
    chk({tag, ".load"}, {47'b0, load}, {47'b0, e_load});
    chk({tag, ".cfg"}, cfg_word, e_cfg);
    chk({tag, ".busy"}, {47'b0, busy}, {47'b0, e_busy});
    chk({tag, ".done"}, {47'b0, done}, {47'b0, e_done});
    chk({tag, ".ready"}, {47'b0, pkt_ready}, {47'b0, e_ready});
    chk({tag, ".flag"}, {46'b0, in_flag}, 48'd0);
`ifdef CONFIG_LOADER_ERR_EN
    chk({tag, ".err"}, {47'b0, err}, {47'b0, e_err});
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0; num_packets = '0; run_cycles = '0; pkt_valid = 1'b0; pkt_data = '0;
  endtask

  initial begin
    reset = 1'b0;
    idle_in();
    // start,num,run,valid,data | load,cfg,busy,done,ready
    tbl[0]  = '{1'b0, 8'd0, 16'd0, 1'b1, WA, 1'b0, N, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 8'd0, 16'd0, 1'b1, WB, 1'b0, N, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 8'd0, 16'd0, 1'b1, WC, 1'b0, N, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 8'd3, 16'd5, 1'b0, N,  1'b0, N, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 8'd0, 16'd0, 1'b0, N,  1'b1, WA, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 8'd0, 16'd0, 1'b0, N,  1'b1, WB, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 8'd0, 16'd0, 1'b0, N,  1'b1, WC, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 8'd0, 16'd0, 1'b0, N,  1'b1, N, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 8'd0, 16'd0, 1'b0, N,  1'b1, N, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'd0, 16'd0, 1'b0, N,  1'b0, N, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 8'd7, 16'd9, 1'b0, N,  1'b0, N, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 8'd0, 16'd0, 1'b0, N,  1'b0, N, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 8'd0, 16'd0, 1'b0, N,  1'b0, N, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 8'd0, 16'd0, 1'b0, N,  1'b0, N, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 8'd0, 16'd0, 1'b0, N,  1'b0, N, 1'b1, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 8'd0, 16'd0, 1'b0, N,  1'b0, N, 1'b0, 1'b0, 1'b1};

    // Reset state
    @(negedge clk);
    chk("rst.load", {47'b0, load}, 48'd0);
    chk("rst.cfg", cfg_word, N);
    chk("rst.busy", {47'b0, busy}, 48'd0);
    chk("rst.done", {47'b0, done}, 48'd0);
    chk("rst.ready", {47'b0, pkt_ready}, 48'd0);
    chk("rst.flag", {46'b0, in_flag}, 48'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Three pre-queued words, 3 loaded, drain 2, run 5; start in RUN is ignored
    for (int i = 0; i < 16; i++) begin
      start = tbl[i].start; num_packets = tbl[i].num; run_cycles = tbl[i].run;
      pkt_valid = tbl[i].valid; pkt_data = tbl[i].data;
      cyc($sformatf("vec%0d", i), tbl[i].e_load, tbl[i].e_cfg, tbl[i].e_busy,
          tbl[i].e_done, tbl[i].e_ready);
    end
    idle_in();

    // Second word arrives late: four NOP cycles between the words
    pkt_valid = 1'b1; pkt_data = WA;
    cyc("late.pre", 0, N, 0, 0, 1);
    pkt_valid = 1'b0; start = 1'b1; num_packets = 8'd2; run_cycles = 16'd0;
    cyc("late.start", 0, N, 0, 0, 1);
    start = 1'b0;
    cyc("late.w0", 1, WA, 1, 0, 1);
    cyc("late.nop1", 1, N, 1, 0, 1);
    cyc("late.nop2", 1, N, 1, 0, 1);
    pkt_valid = 1'b1; pkt_data = WB;
    cyc("late.nop3", 1, N, 1, 0, 1);
    pkt_valid = 1'b0;
    cyc("late.nop4", 1, N, 1, 0, 1);
    cyc("late.w1", 1, WB, 1, 0, 1);
    cyc("late.d0", 1, N, 1, 0, 1);
    cyc("late.d1", 1, N, 1, 0, 1);
    cyc("late.fin", 0, N, 1, 1, 1);
    cyc("late.idle", 0, N, 0, 0, 1);

    // Fill to full with no start; start frees a slot and the held push proceeds
    for (int i = 0; i < 4; i++) begin
      pkt_valid = 1'b1; pkt_data = {8'h10 + 8'(i), 40'h5};
      cyc($sformatf("fill.p%0d", i), 0, N, 0, 0, 1);
    end
    pkt_data = {8'h14, 40'h5};
    cyc("fill.full0", 0, N, 0, 0, 0);
    cyc("fill.full1", 0, N, 0, 0, 0);
    start = 1'b1; num_packets = 8'd5; run_cycles = 16'd1;
    cyc("fill.start", 0, N, 0, 0, 0);
    start = 1'b0;
    cyc("fill.l0", 1, {8'h10, 40'h5}, 1, 0, 1);
    pkt_valid = 1'b0;
    for (int i = 1; i < 5; i++) cyc($sformatf("fill.l%0d", i), 1, {8'h10 + 8'(i), 40'h5}, 1, 0, 1);
    cyc("fill.d0", 1, N, 1, 0, 1);
    cyc("fill.d1", 1, N, 1, 0, 1);
    cyc("fill.run", 0, N, 1, 0, 1);
    cyc("fill.fin", 0, N, 1, 1, 1);
    cyc("fill.idle", 0, N, 0, 0, 1);
    idle_in();

    // Zero packets, zero run cycles
    start = 1'b1;
    cyc("zero.start", 0, N, 0, 0, 1);
    start = 1'b0;
    cyc("zero.d0", 1, N, 1, 0, 1);
    cyc("zero.d1", 1, N, 1, 0, 1);
    cyc("zero.fin", 0, N, 1, 1, 1);
    cyc("zero.idle", 0, N, 0, 0, 1);

    // Reset in the second RUN cycle discards the leftover queued word
    pkt_valid = 1'b1; pkt_data = {8'h21, 40'h1};
    cyc("rr.p0", 0, N, 0, 0, 1);
    pkt_data = {8'h22, 40'h2};
    cyc("rr.p1", 0, N, 0, 0, 1);
    pkt_valid = 1'b0; start = 1'b1; num_packets = 8'd1; run_cycles = 16'd4;
    cyc("rr.start", 0, N, 0, 0, 1);
    start = 1'b0;
    cyc("rr.l0", 1, {8'h21, 40'h1}, 1, 0, 1);
    cyc("rr.d0", 1, N, 1, 0, 1);
    cyc("rr.d1", 1, N, 1, 0, 1);
    cyc("rr.run0", 0, N, 1, 0, 1);
    reset = 1'b0;
    #1;
    chk("rr.now.busy", {47'b0, busy}, 48'd0);
    chk("rr.now.ready", {47'b0, pkt_ready}, 48'd0);
    chk("rr.now.flag", {46'b0, in_flag}, 48'd0);
    @(negedge clk);
    chk("rr.hold.load", {47'b0, load}, 48'd0);
    chk("rr.hold.cfg", cfg_word, N);
    chk("rr.hold.done", {47'b0, done}, 48'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("rr.rel.ready", {47'b0, pkt_ready}, 48'd1);
    start = 1'b1; num_packets = 8'd1; run_cycles = 16'd0;
    cyc("rr.restart", 0, N, 0, 0, 1);
    start = 1'b0; pkt_valid = 1'b1; pkt_data = {8'h23, 40'h3};
    cyc("rr.l0b", 1, N, 1, 0, 1);
    pkt_valid = 1'b0;
    cyc("rr.l1b", 1, N, 1, 0, 1);
    cyc("rr.l2b", 1, {8'h23, 40'h3}, 1, 0, 1);
    cyc("rr.d0b", 1, N, 1, 0, 1);
    cyc("rr.d1b", 1, N, 1, 0, 1);
    cyc("rr.finb", 0, N, 1, 1, 1);
    cyc("rr.idleb", 0, N, 0, 0, 1);

`ifdef CONFIG_LOADER_ERR_EN
    // Zero-header word is replaced by NOP and err sticks through done
    pkt_valid = 1'b1; pkt_data = 48'h00_0000_0001;
    cyc("err.push", 0, N, 0, 0, 1);
    pkt_valid = 1'b0; start = 1'b1; num_packets = 8'd1; run_cycles = 16'd1;
    cyc("err.start", 0, N, 0, 0, 1);
    start = 1'b0; e_err = 1'b1;
    cyc("err.l0", 1, N, 1, 0, 1);
    cyc("err.d0", 1, N, 1, 0, 1);
    cyc("err.d1", 1, N, 1, 0, 1);
    cyc("err.run", 0, N, 1, 0, 1);
    cyc("err.fin", 0, N, 1, 1, 1);
    cyc("err.idle", 0, N, 0, 0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning configuration-packet buffer entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the packet counter.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 2, meaning load-high cycles after the last packet so the mesh registers settle.
REQ-004 SHALL have parameter ENTRY_PORT, default 2'd0 (South), meaning the switch input port that is driven on in_flag.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on posedge.
REQ-006 SHALL have port reset, input, 1, meaning the reset; asynchronous and active-low (0 = reset).
REQ-007 SHALL have port start, input, 1, meaning a one-cycle pulse that begins a load-then-run sequence.
REQ-008 SHALL have port num_packets, input, CNT_W, meaning packets to load, sampled on start.
REQ-009 SHALL have port run_cycles, input, 16, meaning compute cycles after loading, sampled on start.
REQ-010 SHALL have ports pkt_valid (input, 1), pkt_ready (output, 1) and pkt_data (input, 48), meaning the host configuration-packet stream.
REQ-011 SHALL have ports load (output, 1), in_flag (output, 2) and cfg_word (output, 48), meaning the mesh-entry switch controls.
REQ-012 SHALL have ports busy (output, 1) and done (output, 1), meaning sequence active and a one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1, meaning a sticky unroutable-packet flag; present only with CONFIG_LOADER_ERR_EN.

Function
REQ-014 SHALL implement the states IDLE, LOAD, DRAIN, RUN and FIN.
REQ-015 SHALL, in IDLE on start, latch num_packets and run_cycles and go to LOAD; if num_packets==0 it SHALL go straight to DRAIN.
REQ-016 SHALL assert pkt_ready while the FIFO is not full, in any state including IDLE; a transfer is pkt_valid&&pkt_ready.
REQ-017 SHALL, in LOAD, assert load; each cycle the FIFO is non-empty it SHALL pop one word onto cfg_word (registered, 1-cycle latency) and increment the sent count.
REQ-018 SHALL drive cfg_word to package constant CFG_NOP (48'h0) in any LOAD cycle with an empty FIFO; load stays high and the count is unchanged.
REQ-019 SHALL go from LOAD to DRAIN in the cycle after the sent count reaches the latched num_packets.
REQ-020 SHALL, in DRAIN, hold load=1 and cfg_word=CFG_NOP for exactly DRAIN_CYCLES cycles, then go to RUN.
REQ-021 SHALL, in RUN, hold load=0 for exactly run_cycles cycles (0 = skip RUN), then go to FIN.
REQ-022 SHALL, in FIN, pulse done for one cycle and return to IDLE.
REQ-023 SHALL hold in_flag at ENTRY_PORT at all times.
REQ-024 SHALL assert busy in every state other than IDLE.
REQ-025 SHALL ignore start when not in IDLE.
REQ-026 SHALL, on simultaneous push and pop, preserve occupancy; a push to a full FIFO cannot occur because pkt_ready=0.
REQ-027 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH; words left over beyond num_packets remain queued for the next sequence.

Reset
REQ-028 SHALL, while reset=0, asynchronously force IDLE, an empty FIFO, zero counters, load=0, cfg_word=CFG_NOP, in_flag=ENTRY_PORT, busy=0, done=0 and err=0.
REQ-029 SHALL, on reset mid-sequence, abort the sequence and discard FIFO contents; pkt_ready SHALL be 0 during reset and 1 on the first cycle after release.

Configuration
REQ-030 SHALL, with CONFIG_LOADER_ERR_EN defined, drop any popped word whose header [47:40]==8'h00, count it as sent, emit CFG_NOP in its place, and set err until reset.
REQ-031 SHALL, without CONFIG_LOADER_ERR_EN, omit the err port and pass every popped word through unchanged.

Structure
REQ-032 SHALL take CFG_NOP, a state enum typedef, a 48-bit cfg_pkt_t typedef and port-direction constants (SOUTH=0, EAST=1, NORTH=2, WEST=3) from shared package accel_pkg.
REQ-033 SHALL implement the buffer as one sub-module, cfg_fifo (parameterised depth, 48-bit, full/empty outputs).

Verification
REQ-034 SHALL cover: 3 words pre-queued, start with num_packets=3, run_cycles=5 -> load high for 3+2 cycles, words in order, then load=0 for 5 cycles, then done pulse.
REQ-035 SHALL cover: num_packets=2 with the second word arriving 4 cycles late -> 4 CFG_NOP cycles between the two words, count unchanged.
REQ-036 SHALL cover: 5 pushes with no start -> pkt_ready falls after the 4th push; start then restores pkt_ready.
REQ-037 SHALL cover: num_packets=0, run_cycles=0 -> DRAIN for 2 cycles, then done on the next cycle.
REQ-038 SHALL cover: reset=0 in the second RUN cycle -> all outputs return to reset values immediately and start is accepted after release.
REQ-039 SHALL cover, with CONFIG_LOADER_ERR_EN: word 48'h00_0000_0001 queued -> CFG_NOP emitted and err=1 stays set through done.
